// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver. Synchronises rx through two flops,
//               detects the start bit, samples each bit once at mid-bit,
//               assembles the byte LSB-first and raises a one-cycle valid
//               strobe on a good stop bit or a one-cycle frame_err strobe
//               on a bad one.
// Ports       : clk       - system clock
//               rst       - synchronous active-high reset
//               rx        - serial line, idle high
//               data      - last correctly framed byte (held between strobes)
//               valid     - one-cycle strobe, data updated this cycle
//               frame_err - one-cycle strobe, stop bit sampled low
//               busy      - high while a frame is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    // Mid-bit sample offset; derived, never overridden.
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_HIGH = 3'd4;

    logic          r_sync1_q;
    logic          r_rx_s_q;
    logic [2:0]    r_state_q,     w_state_d;
    logic [CW-1:0] r_cnt_q,       w_cnt_d;
    logic [3:0]    r_bit_idx_q,   w_bit_idx_d;
    logic [7:0]    r_shift_q,     w_shift_d;
    logic [7:0]    r_data_q,      w_data_d;
    logic          r_valid_q,     w_valid_d;
    logic          r_frame_err_q, w_frame_err_d;

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_bit_idx_d   = r_bit_idx_q;
        w_shift_d     = r_shift_q;
        w_data_d      = r_data_q;
        w_valid_d     = 1'b0;
        w_frame_err_d = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                if (!r_rx_s_q) begin
                    w_bit_idx_d = 4'd0;
                    if (HALF == 0) begin
                        // Start check falls on the detection cycle itself and
                        // trivially passes; go straight to data sampling.
                        w_state_d = c_DATA;
                        w_cnt_d   = '0;
                    end else begin
                        // Detection cycle counts as offset 0, so START is
                        // entered already at offset 1.
                        w_state_d = c_START;
                        w_cnt_d   = c_CNT_ONE;
                    end
                end
            end

            c_START: begin
                if (r_cnt_q == c_CNT_HALF) begin
                    w_cnt_d = '0;
                    if (r_rx_s_q) begin
                        w_state_d = c_IDLE;    // glitch, not a real start bit
                    end else begin
                        w_state_d = c_DATA;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end

            c_DATA: begin
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d   = '0;
                    // LSB arrives first, so shift in from the top.
                    w_shift_d = {r_rx_s_q, r_shift_q[7:1]};
                    if (r_bit_idx_q == 4'd7) begin
                        w_state_d = c_STOP;
                    end else begin
                        w_bit_idx_d = r_bit_idx_q + 4'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end

            c_STOP: begin
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d = '0;
                    if (r_rx_s_q) begin
                        w_data_d  = r_shift_q;
                        w_valid_d = 1'b1;
                        w_state_d = c_IDLE;
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_state_d     = c_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end

            c_WAIT_HIGH: begin
                // A held-low break must not be mistaken for a new start bit.
                if (r_rx_s_q) begin
                    w_state_d = c_IDLE;
                end
            end

            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q     <= 1'b1;
            r_rx_s_q      <= 1'b1;
            r_state_q     <= c_IDLE;
            r_cnt_q       <= '0;
            r_bit_idx_q   <= 4'd0;
            r_shift_q     <= 8'h00;
            r_data_q      <= 8'h00;
            r_valid_q     <= 1'b0;
            r_frame_err_q <= 1'b0;
        end else begin
            r_sync1_q     <= rx;
            r_rx_s_q      <= r_sync1_q;
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_bit_idx_q   <= w_bit_idx_d;
            r_shift_q     <= w_shift_d;
            r_data_q      <= w_data_d;
            r_valid_q     <= w_valid_d;
            r_frame_err_q <= w_frame_err_d;
        end
    end

    assign data      = r_data_q;
    assign valid     = r_valid_q;
    assign frame_err = r_frame_err_q;
    assign busy      = (r_state_q != c_IDLE);

endmodule
`default_nettype wire
